// File: rtl/crono_alarma_bcd.sv
// Up-counting BCD chronometer (hh:mm:ss) with an end-of-count alarm.
// The set-point is latched when the chronometer is enabled. The count then
// advances once per second until it reaches that set-point. The alarm rings
// for a limited number of seconds, or until it is acknowledged or disabled.
module crono_alarma_bcd #(
    parameter int TICK_DIV     = 100_000_000,
    parameter int RING_SECONDS = 5
) (
    input  logic        reloj,
    input  logic        resetM,
    input  logic        act_crono,
    input  logic [7:0]  IN_horacr,
    input  logic [7:0]  IN_mincr,
    input  logic [7:0]  IN_segcr,
    input  logic        stop_alarma,
    output logic        tick_1hz,
    output logic [7:0]  cr_hora,
    output logic [7:0]  cr_min,
    output logic [7:0]  cr_seg,
    output logic [23:0] alarma,
    output logic        A_A
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(RING_SECONDS + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RING
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [RW-1:0] ring_cnt;
    logic [23:0]   target;
    logic [23:0]   count;
    logic [23:0]   count_inc;
    logic [8:0]    seg_next;
    logic [8:0]    min_next;
    logic [8:0]    hora_next;
    logic          tick;
    logic          target_valid;

    // Increment one BCD byte. The byte wraps to zero at its ceiling and
    // reports a carry. The low nibble rolls into the high nibble at 9.
    function automatic logic [8:0] bcd_byte_inc(input logic [7:0] b, input logic [7:0] top);
        logic [8:0] r;
        if (b == top) begin
            r = {1'b1, 8'h00};
        end else if (b[3:0] >= 4'd9) begin
            r = {1'b0, b[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, b[7:4], b[3:0] + 4'd1};
        end
        return r;
    endfunction

    // True when both nibbles hold a decimal digit
    function automatic logic bcd_ok(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

    // A one-cycle second strobe, only while the chronometer is active
    assign tick     = (state != IDLE) && (prescaler == PRE_LAST);
    assign tick_1hz = tick;

    assign cr_hora = count[23:16];
    assign cr_min  = count[15:8];
    assign cr_seg  = count[7:0];
    assign alarma  = count;

    // A set-point with non-decimal digits, an out-of-range field, or a value of zero can never be reached
    assign target_valid = bcd_ok(target[23:16]) && bcd_ok(target[15:8]) && bcd_ok(target[7:0])
                          && (target[23:16] <= 8'h23) && (target[15:8] <= 8'h59)
                          && (target[7:0] <= 8'h59) && (target != 24'h0);

    // Next hh:mm:ss value, with the seconds carry rippling into minutes and hours
    always_comb begin
        seg_next  = bcd_byte_inc(count[7:0], 8'h59);
        min_next  = {1'b0, count[15:8]};
        hora_next = {1'b0, count[23:16]};
        if (seg_next[8]) begin
            min_next = bcd_byte_inc(count[15:8], 8'h59);
        end
        if (seg_next[8] && min_next[8]) begin
            hora_next = bcd_byte_inc(count[23:16], 8'h23);
        end
        count_inc = {hora_next[7:0], min_next[7:0], seg_next[7:0]};
    end

    // Control FSM plus the prescaler, count, ring timer and alarm flag registers
    always_ff @(posedge reloj) begin
        if (resetM) begin
            state     <= IDLE;
            prescaler <= '0;
            ring_cnt  <= '0;
            target    <= '0;
            count     <= '0;
            A_A       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    prescaler <= '0;
                    ring_cnt  <= '0;
                    count     <= '0;
                    A_A       <= 1'b0;
                    if (act_crono) begin
                        target <= {IN_horacr, IN_mincr, IN_segcr};
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (!act_crono) begin
                        state     <= IDLE;
                        prescaler <= '0;
                        ring_cnt  <= '0;
                        count     <= '0;
                        A_A       <= 1'b0;
                    end else begin
                        prescaler <= tick ? '0 : prescaler + PW'(1);
                        if (tick) begin
                            count <= count_inc;
                            if (target_valid && (count_inc == target)) begin
                                state    <= RING;
                                A_A      <= 1'b1;
                                ring_cnt <= '0;
                            end
                        end
                    end
                end
                RING: begin
                    if (!act_crono || stop_alarma) begin
                        state     <= IDLE;
                        prescaler <= '0;
                        ring_cnt  <= '0;
                        count     <= '0;
                        A_A       <= 1'b0;
                    end else begin
                        prescaler <= tick ? '0 : prescaler + PW'(1);
                        if (tick) begin
                            if (ring_cnt == RING_LAST) begin
                                state     <= IDLE;
                                prescaler <= '0;
                                ring_cnt  <= '0;
                                count     <= '0;
                                A_A       <= 1'b0;
                            end else begin
                                ring_cnt <= ring_cnt + RW'(1);
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crono_alarma_bcd.sv
// Directed bench for crono_alarma_bcd with a 4-cycle second and a 3-second ring.
module tb_crono_alarma_bcd;

    logic        reloj;
    logic        resetM;
    logic        act_crono;
    logic [7:0]  IN_horacr;
    logic [7:0]  IN_mincr;
    logic [7:0]  IN_segcr;
    logic        stop_alarma;
    logic        tick_1hz;
    logic [7:0]  cr_hora;
    logic [7:0]  cr_min;
    logic [7:0]  cr_seg;
    logic [23:0] alarma;
    logic        A_A;

    int   vectors     = 0;
    int   miscompares = 0;
    logic alarm_seen  = 1'b0;

    crono_alarma_bcd #(
        .TICK_DIV     (4),
        .RING_SECONDS (3)
    ) dut (
        .reloj       (reloj),
        .resetM      (resetM),
        .act_crono   (act_crono),
        .IN_horacr   (IN_horacr),
        .IN_mincr    (IN_mincr),
        .IN_segcr    (IN_segcr),
        .stop_alarma (stop_alarma),
        .tick_1hz    (tick_1hz),
        .cr_hora     (cr_hora),
        .cr_min      (cr_min),
        .cr_seg      (cr_seg),
        .alarma      (alarma),
        .A_A         (A_A)
    );

    // 10 ns system clock
    initial begin
        reloj = 1'b0;
        forever #5 reloj = ~reloj;
    end

    // Remember any alarm assertion during the long free-running stretches
    always @(negedge reloj) begin
        if (A_A === 1'b1) alarm_seen = 1'b1;
    end

    task automatic applyStimulus(input logic rst, input logic act, input logic [7:0] hr,
                                 input logic [7:0] mn, input logic [7:0] sg, input logic stop);
        resetM      = rst;
        act_crono   = act;
        IN_horacr   = hr;
        IN_mincr    = mn;
        IN_segcr    = sg;
        stop_alarma = stop;
    endtask

    task automatic checkOutput(input string tag, input logic [23:0] got, input logic [23:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge reloj);
        #1;
    endtask

    initial begin
        // Reset held with the chronometer requested on
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 8'h05, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1);
            checkOutput("rst_alarma", alarma, 24'h0);
            checkOutput("rst_A_A", {23'b0, A_A}, 24'h0);
            checkOutput("rst_tick", {23'b0, tick_1hz}, 24'h0);
        end

        // Count up to 00:00:05; the set-point change after entry must be ignored
        $display("[TB] count to 00:00:05");
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h05, 1'b0);
        step(1);
        checkOutput("run_entry", alarma, 24'h0);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h03, 1'b0);
        step(3);
        checkOutput("first_tick", {23'b0, tick_1hz}, 24'h1);
        step(1);
        checkOutput("sec1", alarma, 24'h000001);
        checkOutput("tick_low", {23'b0, tick_1hz}, 24'h0);
        step(4);
        checkOutput("sec2", alarma, 24'h000002);
        step(4);
        checkOutput("sec3", alarma, 24'h000003);
        checkOutput("sec3_noalarm", {23'b0, A_A}, 24'h0);
        step(4);
        checkOutput("sec4", alarma, 24'h000004);
        step(4);
        checkOutput("sec5", alarma, 24'h000005);
        checkOutput("alarm_rise", {23'b0, A_A}, 24'h1);

        // Ring timeout after three ticks with no acknowledge
        step(4);
        checkOutput("ring_hold", alarma, 24'h000005);
        checkOutput("ring_A_A1", {23'b0, A_A}, 24'h1);
        step(4);
        checkOutput("ring_A_A2", {23'b0, A_A}, 24'h1);
        step(3);
        checkOutput("ring_A_A3", {23'b0, A_A}, 24'h1);
        checkOutput("ring_tick3", {23'b0, tick_1hz}, 24'h1);
        step(1);
        checkOutput("ring_timeout", {23'b0, A_A}, 24'h0);
        checkOutput("ring_clear", alarma, 24'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step(2);

        // Acknowledge ignored in RUN, then acknowledge coinciding with a tick in RING
        $display("[TB] acknowledge");
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h02, 1'b0);
        step(1);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h02, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h02, 1'b0);
        step(3);
        checkOutput("ack_run_ignored", alarma, 24'h000001);
        step(4);
        checkOutput("ack_ring_rise", {23'b0, A_A}, 24'h1);
        step(3);
        checkOutput("ack_tick", {23'b0, tick_1hz}, 24'h1);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h02, 1'b1);
        step(1);
        checkOutput("ack_A_A", {23'b0, A_A}, 24'h0);
        checkOutput("ack_clear", alarma, 24'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step(2);

        // Abort mid-run at 00:00:03
        $display("[TB] abort");
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h09, 1'b0);
        step(13);
        checkOutput("abort_pre", alarma, 24'h000003);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h09, 1'b0);
        step(1);
        checkOutput("abort_clear", alarma, 24'h0);
        step(1);

        // Abort arriving together with the tick that would hit the set-point
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0);
        step(4);
        checkOutput("abort_tick", {23'b0, tick_1hz}, 24'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0);
        step(1);
        checkOutput("abort_match_A_A", {23'b0, A_A}, 24'h0);
        checkOutput("abort_match_cnt", alarma, 24'h0);
        step(1);

        // Invalid seconds field: free-runs past a minute without alarm
        $display("[TB] invalid target");
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h7A, 1'b0);
        step(1);
        alarm_seen = 1'b0;
        step(240);
        checkOutput("inv_min", alarma, 24'h000100);
        step(4);
        checkOutput("inv_past", alarma, 24'h000101);
        checkOutput("inv_no_alarm", {23'b0, alarm_seen}, 24'h0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        step(2);

        // Zero target: minute and hour carries
        $display("[TB] carries");
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
        step(1);
        alarm_seen = 1'b0;
        step(236);
        checkOutput("c_0059", alarma, 24'h000059);
        step(4);
        checkOutput("c_0100", alarma, 24'h000100);
        step(14156);
        checkOutput("c_5959", alarma, 24'h005959);
        step(4);
        checkOutput("c_hour", alarma, 24'h010000);
        checkOutput("c_hora", {16'b0, cr_hora}, 24'h000001);
        checkOutput("c_no_alarm", {23'b0, alarm_seen}, 24'h0);

        // Reset while running
        applyStimulus(1'b1, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0);
        step(1);
        checkOutput("midrst_cnt", alarma, 24'h0);
        checkOutput("midrst_tick", {23'b0, tick_1hz}, 24'h0);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0);
        step(5);
        checkOutput("post_rst_cnt", alarma, 24'h000001);
        checkOutput("post_rst_A_A", {23'b0, A_A}, 24'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
